motor_io_mux: RTL and testbench

Parametrised motor-pin I/O multiplexer sitting between the DSHOT controller, the USB-UART passthrough bridge and the bidirectional motor pads. It generalises the single serial/DSHOT mux bit to N motor channels with per-channel passthrough selection and half-duplex direction control with turnaround. It also provides guarded mode switching and an idle timeout that returns to DSHOT. Pad tristate buffers live in the top; this block drives output-enable and data per channel.

---
 rtl/motor_io_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 37 +++
 rtl/motor_io_mux.sv | 189 ++++++++++++++++++
 tb/tb_motor_io_mux.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : motor_io_pkg
// Description : Shared types and constants for the motor pin I/O multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package motor_io_pkg;

    // Mux operating state, exported on o_state with these exact codes.
    typedef enum logic [2:0] {
        GUARD_DSHOT = 3'd0,
        DSHOT       = 3'd1,
        GUARD_PT    = 3'd2,
        PT_RX       = 3'd3,
        PT_TX       = 3'd4
    } state_t;

    // UART lines idle high, so synchronisers come out of reset high too.
    localparam logic c_sync_rst_level = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for asynchronous inputs, vector width
//               and reset level configurable.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff
    import motor_io_pkg::*;
#(
    parameter int   WIDTH     = 1,
    parameter logic RST_LEVEL = c_sync_rst_level
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two back-to-back capture stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= {WIDTH{RST_LEVEL}};
            r_sync <= {WIDTH{RST_LEVEL}};
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/motor_io_mux.sv
`default_nettype none
// ============================================================================
// Module      : motor_io_mux
// Description : Per-motor pad mux between DSHOT and half-duplex UART
//               passthrough, with guarded mode switches, TX turnaround and an
//               idle timeout that falls back to DSHOT.
// Revision    : 1.0 - initial release
// ============================================================================
module motor_io_mux
    import motor_io_pkg::*;
#(
    parameter int NUM_MOTORS          = 4,
    parameter int GUARD_CYCLES        = 7200,
    parameter int TURNAROUND_CYCLES   = 720,
    parameter int IDLE_TIMEOUT_CYCLES = 360_000_000,
    parameter int CH_W                = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1
) (
    input  logic                  i_sys_clk,
    input  logic                  i_rst,
    input  logic                  i_mode_dshot,
    input  logic [CH_W-1:0]       i_pt_channel,
    input  logic                  i_timeout_en,
    input  logic [NUM_MOTORS-1:0] i_dshot,
    input  logic                  i_pt_tx,
    output logic                  o_pt_rx,
    input  logic [NUM_MOTORS-1:0] i_motor_in,
    output logic [NUM_MOTORS-1:0] o_motor_out,
    output logic [NUM_MOTORS-1:0] o_motor_oe,
    output logic [2:0]            o_state,
    output logic                  o_timeout_evt,
    output logic                  o_pt_locked
);

    localparam int c_guard_w = $clog2(GUARD_CYCLES + 1);
    localparam int c_turn_w  = $clog2(TURNAROUND_CYCLES + 1);
    localparam int c_idle_w  = $clog2(IDLE_TIMEOUT_CYCLES + 1);

    localparam logic [c_guard_w-1:0]  c_guard_one  = c_guard_w'(1);
    localparam logic [c_guard_w-1:0]  c_guard_last = c_guard_w'(GUARD_CYCLES - 1);
    localparam logic [c_guard_w-1:0]  c_guard_max  = c_guard_w'(GUARD_CYCLES);
    localparam logic [c_turn_w-1:0]   c_turn_one   = c_turn_w'(1);
    localparam logic [c_turn_w-1:0]   c_turn_last  = c_turn_w'(TURNAROUND_CYCLES - 1);
    localparam logic [c_turn_w-1:0]   c_turn_max   = c_turn_w'(TURNAROUND_CYCLES);
    localparam logic [c_idle_w-1:0]   c_idle_one   = c_idle_w'(1);
    localparam logic [c_idle_w-1:0]   c_idle_limit = c_idle_w'(IDLE_TIMEOUT_CYCLES);
    localparam logic [NUM_MOTORS-1:0] c_bit0       = NUM_MOTORS'(1);

    logic                  w_tx_s;
    logic [NUM_MOTORS-1:0] w_motor_s;

    state_t                r_state;
    logic [CH_W-1:0]       r_sel;
    logic [c_guard_w-1:0]  r_guard_cnt;
    logic [c_turn_w-1:0]   r_turn_cnt;
    logic [c_idle_w-1:0]   r_idle_cnt;
    logic                  r_tx_prev;
    logic [NUM_MOTORS-1:0] r_motor_prev;

    state_t                w_next;
    logic [CH_W-1:0]       w_sel_next;
    logic [NUM_MOTORS-1:0] w_mask;
    logic                  w_in_pt;
    logic                  w_sel_rx;
    logic                  w_act_edge;
    logic                  w_ch_ok;
    logic                  w_idle_hit;
    logic [31:0]           w_ch_ext;
    logic [NUM_MOTORS-1:0] w_oe_nxt;
    logic [NUM_MOTORS-1:0] w_out_nxt;
    logic                  w_rx_nxt;

    sync_2ff #(.WIDTH(1), .RST_LEVEL(c_sync_rst_level)) u_sync_tx (
        .clk (i_sys_clk),
        .rst (i_rst),
        .d   (i_pt_tx),
        .q   (w_tx_s)
    );

    sync_2ff #(.WIDTH(NUM_MOTORS), .RST_LEVEL(c_sync_rst_level)) u_sync_motor (
        .clk (i_sys_clk),
        .rst (i_rst),
        .d   (i_motor_in),
        .q   (w_motor_s)
    );

    assign w_in_pt    = (r_state == PT_RX) || (r_state == PT_TX);
    assign w_sel_rx   = w_motor_s[r_sel];
    // Any transition on either UART direction counts as link activity
    assign w_act_edge = (w_tx_s != r_tx_prev) || (w_sel_rx != r_motor_prev[r_sel]);
    assign w_ch_ext   = 32'(i_pt_channel);
    assign w_ch_ok    = w_ch_ext < 32'(NUM_MOTORS);
    assign w_idle_hit = w_in_pt && i_timeout_en && (r_idle_cnt >= c_idle_limit);

    // Next-state decision; timeout and DSHOT request override any UART activity
    always_comb begin
        w_next = r_state;
        case (r_state)
            GUARD_DSHOT: if (r_guard_cnt >= c_guard_last) w_next = DSHOT;
            DSHOT:       if (!i_mode_dshot && !o_pt_locked && w_ch_ok) w_next = GUARD_PT;
            GUARD_PT: begin
                if (i_mode_dshot)                    w_next = GUARD_DSHOT;
                else if (r_guard_cnt >= c_guard_last) w_next = PT_RX;
            end
            PT_RX: begin
                if (w_idle_hit || i_mode_dshot) w_next = GUARD_DSHOT;
                else if (!w_tx_s)               w_next = PT_TX;
            end
            PT_TX: begin
                if (w_idle_hit || i_mode_dshot)            w_next = GUARD_DSHOT;
                else if (w_tx_s && r_turn_cnt >= c_turn_last) w_next = PT_RX;
            end
            default: w_next = GUARD_DSHOT;
        endcase
    end

    // Channel is captured only on the DSHOT -> GUARD_PT transition
    assign w_sel_next = (r_state == DSHOT && w_next == GUARD_PT) ? i_pt_channel : r_sel;
    assign w_mask     = c_bit0 << w_sel_next;

    // Pad drive for the state being entered, so outputs change with the state
    always_comb begin
        w_oe_nxt  = '1;
        w_out_nxt = '0;
        w_rx_nxt  = 1'b1;
        case (w_next)
            DSHOT:    w_out_nxt = i_dshot;
            GUARD_PT: w_out_nxt = w_mask;
            PT_RX: begin
                w_oe_nxt  = ~w_mask;
                w_out_nxt = w_mask;
                w_rx_nxt  = w_sel_rx;
            end
            PT_TX:    w_out_nxt = w_tx_s ? w_mask : '0;
            default: ;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= GUARD_DSHOT;
            r_sel         <= '0;
            r_guard_cnt   <= '0;
            r_turn_cnt    <= '0;
            r_idle_cnt    <= '0;
            r_tx_prev     <= c_sync_rst_level;
            r_motor_prev  <= {NUM_MOTORS{c_sync_rst_level}};
            o_motor_oe    <= '1;
            o_motor_out   <= '0;
            o_pt_rx       <= 1'b1;
            o_state       <= GUARD_DSHOT;
            o_timeout_evt <= 1'b0;
            o_pt_locked   <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_sel        <= w_sel_next;
            r_tx_prev    <= w_tx_s;
            r_motor_prev <= w_motor_s;

            if ((w_next == GUARD_DSHOT || w_next == GUARD_PT) && w_next == r_state)
                r_guard_cnt <= (r_guard_cnt < c_guard_max) ? r_guard_cnt + c_guard_one : r_guard_cnt;
            else
                r_guard_cnt <= '0;

            if (r_state == PT_TX && w_next == PT_TX && w_tx_s)
                r_turn_cnt <= (r_turn_cnt < c_turn_max) ? r_turn_cnt + c_turn_one : r_turn_cnt;
            else
                r_turn_cnt <= '0;

            if (w_in_pt && (w_next == PT_RX || w_next == PT_TX) && !w_act_edge)
                r_idle_cnt <= (r_idle_cnt < c_idle_limit) ? r_idle_cnt + c_idle_one : r_idle_cnt;
            else
                r_idle_cnt <= '0;

            o_motor_oe    <= w_oe_nxt;
            o_motor_out   <= w_out_nxt;
            o_pt_rx       <= w_rx_nxt;
            o_state       <= w_next;
            o_timeout_evt <= w_idle_hit;

            if (w_idle_hit)
                o_pt_locked <= 1'b1;
            else if (i_mode_dshot)
                o_pt_locked <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_motor_io_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_io_mux
// Description : Self-checking bench for motor_io_mux with a reference model
//               of the passthrough line behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_io_mux;

    localparam int N       = 4;
    localparam int GUARD   = 16;
    localparam int TURN    = 8;
    localparam int TIMEOUT = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_dshot;
    logic [1:0] pt_channel;
    logic       timeout_en;
    logic [3:0] dshot;
    logic       pt_tx;
    logic       pt_rx;
    logic [3:0] motor_in;
    logic [3:0] motor_out;
    logic [3:0] motor_oe;
    logic [2:0] state;
    logic       timeout_evt;
    logic       pt_locked;

    int checks = 0;
    int errors = 0;
    int step_no = 0;
    int last_change = 0;

    // Input histories, one entry per clock, used to derive lagged expectations
    logic       txq[$];
    logic       rxq[$];
    logic [3:0] dq[$];

    // Passthrough reference model (selected channel is motor 2)
    bit         m_in_tx;
    int         m_highs;
    logic [2:0] exp_state;
    logic [3:0] exp_oe, exp_out, exp_mask;
    logic       exp_rx;

    motor_io_mux #(
        .NUM_MOTORS          (N),
        .GUARD_CYCLES        (GUARD),
        .TURNAROUND_CYCLES   (TURN),
        .IDLE_TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .i_sys_clk     (clk),
        .i_rst         (rst),
        .i_mode_dshot  (mode_dshot),
        .i_pt_channel  (pt_channel),
        .i_timeout_en  (timeout_en),
        .i_dshot       (dshot),
        .i_pt_tx       (pt_tx),
        .o_pt_rx       (pt_rx),
        .i_motor_in    (motor_in),
        .o_motor_out   (motor_out),
        .o_motor_oe    (motor_oe),
        .o_state       (state),
        .o_timeout_evt (timeout_evt),
        .o_pt_locked   (pt_locked)
    );

    always #5 clk = ~clk;

    // Record the inputs presented for the coming edge, then sample at the falling edge
    task automatic advance();
        if (pt_tx !== txq[$] || motor_in[2] !== rxq[$]) last_change = step_no + 1;
        txq.push_back(pt_tx);
        rxq.push_back(motor_in[2]);
        dq.push_back(dshot);
        @(negedge clk);
        step_no++;
    endtask

    // Serial data reaches the pads / bridge three edges after it is driven
    function automatic void pt_model();
        logic lt, lr;
        lt = txq[txq.size() - 3];
        lr = rxq[rxq.size() - 3];
        if (!m_in_tx) begin
            if (!lt) begin
                m_in_tx = 1'b1;
                m_highs = 0;
            end
        end else begin
            m_highs = lt ? m_highs + 1 : 0;
            if (m_highs >= TURN) m_in_tx = 1'b0;
        end
        if (m_in_tx) begin
            exp_state = 3'd4; exp_oe = 4'hF; exp_mask = 4'hF;
            exp_out = {1'b0, lt, 2'b00}; exp_rx = 1'b1;
        end else begin
            exp_state = 3'd3; exp_oe = 4'b1011; exp_mask = 4'b1011;
            exp_out = 4'b0000; exp_rx = lr;
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1; mode_dshot = 1'b1; pt_channel = 2'd0; timeout_en = 1'b0;
        dshot = 4'b1010; pt_tx = 1'b1; motor_in = 4'hF;
        repeat (3) @(negedge clk);
        checks++;
        if (motor_oe !== 4'hF || motor_out !== 4'h0 || pt_rx !== 1'b1 || state !== 3'd0 ||
            timeout_evt !== 1'b0 || pt_locked !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: oe=%b out=%b rx=%b st=%0d evt=%b lk=%b, want oe=1111 out=0000 rx=1 st=0 evt=0 lk=0",
                     motor_oe, motor_out, pt_rx, state, timeout_evt, pt_locked);
        end
        rst = 1'b0;
        for (int k = 1; k < GUARD; k++) begin
            advance();
            checks++;
            if (motor_out !== 4'h0 || state !== 3'd0 || motor_oe !== 4'hF) begin
                errors++;
                $display("FAIL reset_guard[%0d]: out=%b st=%0d oe=%b, want out=0000 st=0 oe=1111", k, motor_out, state, motor_oe);
            end
        end
        advance();
        checks++;
        if (motor_out !== 4'b1010 || state !== 3'd1 || motor_oe !== 4'hF) begin
            errors++;
            $display("FAIL reset_to_dshot: out=%b st=%0d oe=%b, want out=1010 st=1 oe=1111", motor_out, state, motor_oe);
        end
    endtask

    task automatic test_dshot_random();
        for (int i = 0; i < 30; i++) begin
            dshot = 4'($urandom);
            advance();
            checks++;
            if (motor_out !== dq[$] || motor_oe !== 4'hF || pt_rx !== 1'b1 || state !== 3'd1) begin
                errors++;
                $display("FAIL dshot_pass[%0d]: out=%b oe=%b rx=%b st=%0d, want out=%b oe=1111 rx=1 st=1",
                         i, motor_out, motor_oe, pt_rx, state, dq[$]);
            end
        end
    endtask

    task automatic test_pt_entry();
        mode_dshot = 1'b0; pt_channel = 2'd2;
        for (int k = 0; k < GUARD; k++) begin
            advance();
            checks++;
            if (state !== 3'd2 || motor_out !== 4'b0100 || motor_oe !== 4'hF) begin
                errors++;
                $display("FAIL pt_guard[%0d]: st=%0d out=%b oe=%b, want st=2 out=0100 oe=1111", k, state, motor_out, motor_oe);
            end
        end
        m_in_tx = 1'b0; m_highs = 0;
        pt_channel = 2'd0;
        for (int i = 0; i < 50; i++) begin
            motor_in = 4'($urandom);
            if (i < 6) motor_in[2] = 1'b0;
            advance();
            pt_model();
            checks++;
            if (state !== exp_state || motor_oe !== exp_oe || (motor_out & exp_mask) !== exp_out || pt_rx !== exp_rx) begin
                errors++;
                $display("FAIL pt_rx[%0d]: st=%0d oe=%b out=%b rx=%b, want st=%0d oe=%b out&%b=%b rx=%b",
                         i, state, motor_oe, motor_out, pt_rx, exp_state, exp_oe, exp_mask, exp_out, exp_rx);
            end
        end
    endtask

    task automatic test_pt_tx();
        logic cur;
        for (int i = 0; i < 230; i++) begin
            if (i < 25) begin
                pt_tx = (i < 5) ? 1'b0 : 1'b1;
                motor_in = 4'hF;
            end else if (i < 210) begin
                cur = pt_tx;
                if ($urandom_range(0, 3) == 0) cur = ~cur;
                pt_tx = cur;
                motor_in = 4'($urandom);
            end else begin
                pt_tx = 1'b1;
                motor_in = 4'hF;
            end
            advance();
            pt_model();
            checks++;
            if (state !== exp_state || motor_oe !== exp_oe || (motor_out & exp_mask) !== exp_out || pt_rx !== exp_rx) begin
                errors++;
                $display("FAIL pt_tx[%0d]: st=%0d oe=%b out=%b rx=%b, want st=%0d oe=%b out&%b=%b rx=%b",
                         i, state, motor_oe, motor_out, pt_rx, exp_state, exp_oe, exp_mask, exp_out, exp_rx);
            end
        end
    endtask

    task automatic test_timeout();
        bit found;
        int evt_step;
        found = 1'b0; evt_step = 0;
        timeout_en = 1'b1;
        for (int i = 0; i < TIMEOUT + 100 && !found; i++) begin
            advance();
            if (timeout_evt === 1'b1) begin
                found = 1'b1;
                evt_step = step_no;
            end
        end
        checks++;
        if (!found || evt_step - last_change < TIMEOUT || evt_step - last_change > TIMEOUT + 8) begin
            errors++;
            $display("FAIL timeout_time: found=%0d idle_cycles=%0d, want found=1 idle_cycles in [%0d,%0d]",
                     found, evt_step - last_change, TIMEOUT, TIMEOUT + 8);
        end
        checks++;
        if (state !== 3'd0 || pt_locked !== 1'b1 || motor_out !== 4'h0 || motor_oe !== 4'hF) begin
            errors++;
            $display("FAIL timeout_entry: st=%0d lk=%b out=%b oe=%b, want st=0 lk=1 out=0000 oe=1111", state, pt_locked, motor_out, motor_oe);
        end
        advance();
        checks++;
        if (timeout_evt !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse_width: evt=%b, want 0", timeout_evt);
        end
        for (int k = 2; k < GUARD; k++) begin
            advance();
            checks++;
            if (state !== 3'd0 || motor_out !== 4'h0) begin
                errors++;
                $display("FAIL timeout_guard[%0d]: st=%0d out=%b, want st=0 out=0000", k, state, motor_out);
            end
        end
        for (int i = 0; i < 12; i++) begin
            dshot = 4'($urandom);
            advance();
            checks++;
            if (state !== 3'd1 || pt_locked !== 1'b1 || motor_out !== dq[$]) begin
                errors++;
                $display("FAIL locked_hold[%0d]: st=%0d lk=%b out=%b, want st=1 lk=1 out=%b", i, state, pt_locked, motor_out, dq[$]);
            end
        end
        timeout_en = 1'b0;
        mode_dshot = 1'b1;
        advance();
        checks++;
        if (pt_locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_clear: lk=%b, want 0", pt_locked);
        end
    endtask

    task automatic test_abort();
        logic [5:0] pat;
        pat = 6'b110100;
        mode_dshot = 1'b0; pt_channel = 2'd2;
        for (int k = 0; k < GUARD; k++) begin
            advance();
            if (k == 3) pt_channel = 2'd0;
            checks++;
            if (state !== 3'd2) begin
                errors++;
                $display("FAIL reentry_guard[%0d]: st=%0d, want 2", k, state);
            end
        end
        m_in_tx = 1'b0; m_highs = 0;
        for (int i = 0; i < 7; i++) begin
            pt_tx = (i == 0) ? 1'b1 : pat[i-1];
            advance();
            pt_model();
            checks++;
            if (state !== exp_state || motor_oe !== exp_oe || (motor_out & exp_mask) !== exp_out || pt_rx !== exp_rx) begin
                errors++;
                $display("FAIL latched_ch[%0d]: st=%0d oe=%b out=%b rx=%b, want st=%0d oe=%b out&%b=%b rx=%b",
                         i, state, motor_oe, motor_out, pt_rx, exp_state, exp_oe, exp_mask, exp_out, exp_rx);
            end
        end
        checks++;
        if (state !== 3'd4) begin
            errors++;
            $display("FAIL abort_precond: st=%0d, want 4", state);
        end
        mode_dshot = 1'b1;
        pt_tx = 1'b0;
        for (int k = 0; k < GUARD; k++) begin
            advance();
            if (k == 0) pt_tx = 1'b1;
            checks++;
            if (state !== 3'd0 || motor_out !== 4'h0 || motor_oe !== 4'hF || pt_rx !== 1'b1) begin
                errors++;
                $display("FAIL abort_guard[%0d]: st=%0d out=%b oe=%b rx=%b, want st=0 out=0000 oe=1111 rx=1",
                         k, state, motor_out, motor_oe, pt_rx);
            end
        end
        advance();
        checks++;
        if (state !== 3'd1 || motor_out !== dq[$]) begin
            errors++;
            $display("FAIL abort_to_dshot: st=%0d out=%b, want st=1 out=%b", state, motor_out, dq[$]);
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [3:0] one;
        logic [1:0] ch;
        bit         reached;
        one = 4'b0001;
        ch = 2'($urandom_range(0, 3));
        mode_dshot = 1'b0; pt_channel = ch;
        repeat (GUARD + 1) advance();
        checks++;
        if (state !== 3'd3 || motor_oe !== ~(one << ch)) begin
            errors++;
            $display("FAIL rand_ch_rx: ch=%0d st=%0d oe=%b, want st=3 oe=%b", ch, state, motor_oe, ~(one << ch));
        end
        pt_tx = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 8 && !reached; i++) begin
            advance();
            if (state === 3'd4) reached = 1'b1;
        end
        checks++;
        if (!reached || motor_out !== 4'h0 || motor_oe !== 4'hF) begin
            errors++;
            $display("FAIL rand_ch_tx: reached=%0d out=%b oe=%b, want reached=1 out=0000 oe=1111", reached, motor_out, motor_oe);
        end
        pt_tx = 1'b1;
        advance();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (motor_oe !== 4'hF || motor_out !== 4'h0 || pt_rx !== 1'b1 || state !== 3'd0 ||
            timeout_evt !== 1'b0 || pt_locked !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: oe=%b out=%b rx=%b st=%0d evt=%b lk=%b, want oe=1111 out=0000 rx=1 st=0 evt=0 lk=0",
                     motor_oe, motor_out, pt_rx, state, timeout_evt, pt_locked);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            txq.push_back(1'b1);
            rxq.push_back(1'b1);
            dq.push_back(4'h0);
        end
        test_reset();
        test_dshot_random();
        test_pt_entry();
        test_pt_tx();
        test_timeout();
        test_abort();
        test_reset_mid_tx();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
